// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - shared state, mode and replica-select definitions
package tmr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } tmr_state_e;

  localparam logic MODE_FLIP  = 1'b0;
  localparam logic MODE_STUCK = 1'b1;

  localparam int TGT_A = 0;
  localparam int TGT_B = 1;
  localparam int TGT_C = 2;

endpackage

// File: rtl/tmr_fault_injector_if.sv
// rtl/tmr_fault_injector_if.sv - golden input stream and aligned replica output bus
interface tmr_fault_injector_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] data_out;

  modport master (
    output in_valid, in_data,
    input  out_valid, r_a, r_b, r_c, data_out
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, r_a, r_b, r_c, data_out
  );
endinterface

// File: rtl/tmr_majority_voter.sv
// rtl/tmr_majority_voter.sv - combinational bitwise 2-of-3 majority
module tmr_majority_voter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);
  assign y = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/tmr_fault_injector.sv
// rtl/tmr_fault_injector.sv - triggered trojan-style corruption of a triplicated stream
module tmr_fault_injector
  import tmr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [WIDTH-1:0]     cfg_trig_pat,
  input  logic [WIDTH-1:0]     cfg_trig_mask,
  input  logic [CNT_W-1:0]     cfg_trig_n,
  input  logic [CNT_W-1:0]     cfg_burst,
  input  logic [2:0]           cfg_tgt,
  input  logic                 cfg_mode,
  input  logic [WIDTH-1:0]     cfg_mask,
  input  logic [WIDTH-1:0]     cfg_val,
  input  logic                 cfg_repeat,
  input  logic                 arm,
  input  logic                 disarm,
  tmr_fault_injector_if.slave  bus,
  output logic [1:0]           state_o,
  output logic                 injecting,
  output logic [15:0]          inject_cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [WIDTH-1:0] trig_pat_q, trig_mask_q, mask_q, val_q;
  logic [CNT_W-1:0] trig_n_q, burst_q;
  logic [2:0]       tgt_q;
  logic             mode_q, repeat_q;

  tmr_state_e       state_q, state_d;
  logic [CNT_W-1:0] trig_cnt_q, burst_cnt_q;
  logic [CNT_W-1:0] trig_lim, burst_lim;
  logic             trig_match, trig_last, burst_last;
  logic             inj_en, hit_a, hit_b, hit_c;
  logic [WIDTH-1:0] c_a, c_b, c_c, maj;

  function automatic logic [WIDTH-1:0] payload(
    input logic [WIDTH-1:0] d,
    input logic             mode,
    input logic [WIDTH-1:0] msk,
    input logic [WIDTH-1:0] val
  );
    case (mode)
      MODE_FLIP:  payload = d ^ msk;
      MODE_STUCK: payload = (d & ~msk) | (val & msk);
      default:    payload = d;
    endcase
  endfunction

  // Config is frozen outside IDLE so a running attack never changes shape mid-flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_pat_q  <= '0;
      trig_mask_q <= '0;
      trig_n_q    <= '0;
      burst_q     <= '0;
      tgt_q       <= '0;
      mode_q      <= 1'b0;
      mask_q      <= '0;
      val_q       <= '0;
      repeat_q    <= 1'b0;
    end else if (cfg_load && state_q == ST_IDLE) begin
      trig_pat_q  <= cfg_trig_pat;
      trig_mask_q <= cfg_trig_mask;
      trig_n_q    <= cfg_trig_n;
      burst_q     <= cfg_burst;
      tgt_q       <= cfg_tgt;
      mode_q      <= cfg_mode;
      mask_q      <= cfg_mask;
      val_q       <= cfg_val;
      repeat_q    <= cfg_repeat;
    end
  end

  assign trig_lim   = (trig_n_q == '0) ? ONE : trig_n_q;
  assign burst_lim  = (burst_q == '0) ? ONE : burst_q;
  assign trig_match = bus.in_valid && (((bus.in_data ^ trig_pat_q) & trig_mask_q) == '0);
  assign trig_last  = (trig_cnt_q == trig_lim - ONE);
  assign burst_last = (burst_cnt_q == burst_lim - ONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (disarm) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (arm) state_d = ST_ARMED;
        ST_ARMED:  if (trig_match && trig_last) state_d = ST_ACTIVE;
        ST_ACTIVE: if (bus.in_valid && burst_last) state_d = repeat_q ? ST_ARMED : ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    inj_en = bus.in_valid && (state_q == ST_ACTIVE) && !disarm;
    hit_a  = inj_en && tgt_q[TGT_A];
    hit_b  = inj_en && tgt_q[TGT_B];
    hit_c  = inj_en && tgt_q[TGT_C];
  end

  always_ff @(posedge clk) begin
    if (rst || disarm) begin
      trig_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          trig_cnt_q  <= '0;
          burst_cnt_q <= '0;
        end
        ST_ARMED: begin
          if (trig_match) begin
            trig_cnt_q  <= trig_last ? '0 : trig_cnt_q + ONE;
            burst_cnt_q <= '0;
          end
        end
        ST_ACTIVE: begin
          if (bus.in_valid) begin
            burst_cnt_q <= burst_last ? '0 : burst_cnt_q + ONE;
            trig_cnt_q  <= '0;
          end
        end
        default: begin
          trig_cnt_q  <= '0;
          burst_cnt_q <= '0;
        end
      endcase
    end
  end

  assign c_a = hit_a ? payload(bus.in_data, mode_q, mask_q, val_q) : bus.in_data;
  assign c_b = hit_b ? payload(bus.in_data, mode_q, mask_q, val_q) : bus.in_data;
  assign c_c = hit_c ? payload(bus.in_data, mode_q, mask_q, val_q) : bus.in_data;

  tmr_majority_voter #(.WIDTH(WIDTH)) u_voter (
    .a (c_a),
    .b (c_b),
    .c (c_c),
    .y (maj)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.r_a       <= '0;
      bus.r_b       <= '0;
      bus.r_c       <= '0;
      bus.data_out  <= '0;
      injecting     <= 1'b0;
      inject_cnt    <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.r_a      <= c_a;
        bus.r_b      <= c_b;
        bus.r_c      <= c_c;
        bus.data_out <= maj;
      end
      injecting <= hit_a || hit_b || hit_c;
      if ((hit_a || hit_b || hit_c) && inject_cnt != 16'hFFFF)
        inject_cnt <= inject_cnt + 16'd1;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_tmr_fault_injector.sv
// tb/tb_tmr_fault_injector.sv - self-checking bench for tmr_fault_injector
module tb_tmr_fault_injector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] c_pat = '0, c_tmask = '0, c_mask = '0, c_val = '0;
  logic [7:0] c_n = '0, c_b = '0;
  logic [2:0] c_tgt = '0;
  logic       c_mode = 1'b0, c_rep = 1'b0;
  logic       arm = 1'b0, disarm = 1'b0;
  logic [1:0] state_o;
  logic       injecting;
  logic [15:0] inject_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int         mst = 0, mtrig = 0, mburst = 0;
  logic [7:0] m_pat = '0, m_tmask = '0, m_mask = '0, m_val = '0;
  int         m_n = 0, m_b = 0;
  logic [2:0] m_tgt = '0;
  logic       m_mode = 1'b0, m_rep = 1'b0;
  logic [7:0] e_r [3];
  logic [7:0] e_do = '0;
  logic       e_ov = 1'b0, e_inj = 1'b0;
  logic [15:0] e_cnt = '0;

  tmr_fault_injector_if #(.WIDTH(8)) bus ();

  tmr_fault_injector #(.WIDTH(8), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_load      (cfg_load),
    .cfg_trig_pat  (c_pat),
    .cfg_trig_mask (c_tmask),
    .cfg_trig_n    (c_n),
    .cfg_burst     (c_b),
    .cfg_tgt       (c_tgt),
    .cfg_mode      (c_mode),
    .cfg_mask      (c_mask),
    .cfg_val       (c_val),
    .cfg_repeat    (c_rep),
    .arm           (arm),
    .disarm        (disarm),
    .bus           (bus),
    .state_o       (state_o),
    .injecting     (injecting),
    .inject_cnt    (inject_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ra"},  {24'd0, bus.r_a},      {24'd0, e_r[0]});
    chk({tag, "_rb"},  {24'd0, bus.r_b},      {24'd0, e_r[1]});
    chk({tag, "_rc"},  {24'd0, bus.r_c},      {24'd0, e_r[2]});
    chk({tag, "_do"},  {24'd0, bus.data_out}, {24'd0, e_do});
    chk({tag, "_ov"},  {31'd0, bus.out_valid}, {31'd0, e_ov});
    chk({tag, "_inj"}, {31'd0, injecting},    {31'd0, e_inj});
    chk({tag, "_cnt"}, {16'd0, inject_cnt},   {16'd0, e_cnt});
    chk({tag, "_st"},  {30'd0, state_o},      32'(mst));
  endtask

  task automatic do_reset(input bit v, input logic [7:0] d);
    rst = 1'b1; bus.in_valid = v; bus.in_data = d;
    arm = 1'b0; disarm = 1'b0; cfg_load = 1'b0;
    @(posedge clk); #1;
    mst = 0; mtrig = 0; mburst = 0;
    m_pat = '0; m_tmask = '0; m_mask = '0; m_val = '0;
    m_n = 0; m_b = 0; m_tgt = '0; m_mode = 1'b0; m_rep = 1'b0;
    e_r[0] = '0; e_r[1] = '0; e_r[2] = '0; e_do = '0;
    e_ov = 1'b0; e_inj = 1'b0; e_cnt = '0;
    rst = 1'b0;
    check_all("reset");
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit a, input bit da, input bit ld);
    logic [7:0] cx [3];
    bit any;
    int ones;
    int lim;
    bus.in_valid = v; bus.in_data = d; arm = a; disarm = da; cfg_load = ld;
    any = 0;
    for (int i = 0; i < 3; i++) begin
      if (v && mst == 2 && !da && m_tgt[i]) begin
        cx[i] = m_mode ? ((d & ~m_mask) | (m_val & m_mask)) : (d ^ m_mask);
        any = 1;
      end else begin
        cx[i] = d;
      end
    end
    e_ov = v;
    if (v) begin
      for (int i = 0; i < 3; i++) e_r[i] = cx[i];
      for (int k = 0; k < 8; k++) begin
        ones = int'(cx[0][k]) + int'(cx[1][k]) + int'(cx[2][k]);
        e_do[k] = (ones >= 2);
      end
    end
    e_inj = any;
    if (any && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
    if (mst == 0 && ld) begin
      m_pat = c_pat; m_tmask = c_tmask; m_n = int'(c_n); m_b = int'(c_b);
      m_tgt = c_tgt; m_mode = c_mode; m_mask = c_mask; m_val = c_val; m_rep = c_rep;
    end
    if (da) begin
      mst = 0; mtrig = 0; mburst = 0;
    end else if (mst == 0) begin
      if (a) begin mst = 1; mtrig = 0; end
    end else if (mst == 1) begin
      lim = (m_n == 0) ? 1 : m_n;
      if (v && ((d ^ m_pat) & m_tmask) == 8'h00) begin
        mtrig++;
        if (mtrig >= lim) begin mst = 2; mburst = 0; end
      end
    end else begin
      lim = (m_b == 0) ? 1 : m_b;
      if (v) begin
        mburst++;
        if (mburst >= lim) begin mst = m_rep ? 1 : 0; mtrig = 0; end
      end
    end
    @(posedge clk); #1;
    check_all("beat");
  endtask

  task automatic set_cfg(input logic [7:0] pat, input logic [7:0] tmask, input logic [7:0] n,
                         input logic [7:0] b, input logic [2:0] tgt, input logic mode,
                         input logic [7:0] mask, input logic [7:0] val, input logic rep);
    c_pat = pat; c_tmask = tmask; c_n = n; c_b = b; c_tgt = tgt;
    c_mode = mode; c_mask = mask; c_val = val; c_rep = rep;
  endtask

  logic [7:0] seq2 [7];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    e_r[0] = '0; e_r[1] = '0; e_r[2] = '0;
    seq2[0] = 8'hA5; seq2[1] = 8'h11; seq2[2] = 8'hA5; seq2[3] = 8'h10;
    seq2[4] = 8'h20; seq2[5] = 8'h30; seq2[6] = 8'h40;

    do_reset(0, 8'h00);

    // pass-through with nothing armed
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    chk("idle_cnt", {16'd0, inject_cnt}, 32'd0);

    // XOR flip on replica a only, single shot
    set_cfg(8'hA5, 8'hFF, 8'd2, 8'd3, 3'b001, 1'b0, 8'h0F, 8'h00, 1'b0);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, seq2[i], 0, 0, 0);
      if (i == 3) chk("tp2_ra_1f", {24'd0, bus.r_a}, 32'h1F);
      if (i == 3) chk("tp2_do_10", {24'd0, bus.data_out}, 32'h10);
    end
    chk("tp2_cnt", {16'd0, inject_cnt}, 32'd3);
    chk("tp2_idle", {30'd0, state_o}, 32'd0);

    // stuck-at on a and b: majority follows the corrupted pair
    set_cfg(8'hA5, 8'hFF, 8'd2, 8'd3, 3'b011, 1'b1, 8'hF0, 8'hFF, 1'b0);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, seq2[i], 0, 0, 0);
      if (i == 4) chk("tp3_do_f0", {24'd0, bus.data_out}, 32'hF0);
      if (i == 4) chk("tp3_rc_20", {24'd0, bus.r_c}, 32'h20);
    end
    chk("tp3_cnt", {16'd0, inject_cnt}, 32'd6);

    // repeat mode, one-beat bursts after every 0x55
    set_cfg(8'h55, 8'hFF, 8'd1, 8'd1, 3'b100, 1'b0, 8'hFF, 8'h00, 1'b1);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'h55, 0, 0, 0);
    chk("tp4_active", {30'd0, state_o}, 32'd2);
    step(1, 8'h01, 0, 0, 0);
    chk("tp4_rc_fe", {24'd0, bus.r_c}, 32'hFE);
    chk("tp4_armed", {30'd0, state_o}, 32'd1);
    step(1, 8'h55, 0, 0, 0);
    step(1, 8'h55, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0);

    // disarm on an ACTIVE beat wins over corruption
    step(1, 8'h55, 0, 0, 0);
    step(1, 8'h33, 0, 1, 0);
    chk("tp5_clean", {24'd0, bus.r_c}, 32'h33);
    chk("tp5_idle", {30'd0, state_o}, 32'd0);
    step(1, 8'h55, 0, 0, 0);
    step(1, 8'h66, 0, 0, 0);
    step(1, 8'h55, 1, 1, 0);

    // cfg_load while ARMED must not take effect
    step(0, 8'h00, 1, 0, 0);
    set_cfg(8'h77, 8'hFF, 8'd1, 8'd1, 3'b001, 1'b0, 8'h01, 8'h00, 1'b0);
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h77, 0, 0, 0);
    step(1, 8'h55, 0, 0, 0);
    step(1, 8'h12, 0, 0, 0);
    chk("tp6_old_cfg", {24'd0, bus.r_c}, 32'hED);

    // reset in the middle of a long burst
    step(0, 8'h00, 0, 1, 0);
    set_cfg(8'h55, 8'hFF, 8'd1, 8'd10, 3'b111, 1'b0, 8'hFF, 8'h00, 1'b0);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'h55, 0, 0, 0);
    step(1, 8'h01, 0, 0, 0);
    do_reset(1, 8'h02);
    step(1, 8'h55, 0, 0, 0);
    step(1, 8'h56, 0, 0, 0);
    step(1, 8'h57, 1, 0, 0);
    step(1, 8'h55, 0, 0, 0);
    step(1, 8'h58, 0, 0, 0);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      bit ld, a, da, v;
      logic [7:0] d;
      ld = ($urandom_range(0, 9) == 0);
      if (ld)
        set_cfg(8'h3C, 8'($urandom_range(0, 255) | 8'hC0), 8'($urandom_range(0, 3)),
                8'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      a  = ($urandom_range(0, 5) == 0);
      da = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 4) != 0);
      d  = ($urandom_range(0, 1) == 0) ? 8'h3C : 8'($urandom);
      step(v, d, a, da, ld);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tmr_fault_injector.md
Name: tmr_fault_injector

Overview:
- Source-side companion to the TMR mismatch/trojan monitor.
- Takes a golden data stream and fans it out to three replica buses r_a/r_b/r_c, plus a bitwise-majority data_out.
- Injects trigger-activated, trojan-style corruption into selected replicas so the monitor's fault_flag/sus_trojan paths can be exercised in closed loop.
- Outputs are registered and mutually aligned, so they connect directly to the monitor's inputs.

Parameters:
- WIDTH, 8, data/replica width.
- CNT_W, 8, width of the trigger-count and burst-length config fields and their internal counters.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- cfg_load  input  1  latch all cfg_* fields; honoured only in IDLE, ignored otherwise.
- cfg_trig_pat  input  WIDTH  trigger match pattern.
- cfg_trig_mask  input  WIDTH  bits compared in trigger match (1 = compare).
- cfg_trig_n  input  CNT_W  matching beats required to fire; 0 treated as 1.
- cfg_burst  input  CNT_W  corrupted beats per activation; 0 treated as 1.
- cfg_tgt  input  3  replica select: bit0 = a, bit1 = b, bit2 = c.
- cfg_mode  input  1  0 = XOR flip, 1 = stuck-at.
- cfg_mask  input  WIDTH  bits affected by the payload.
- cfg_val  input  WIDTH  stuck-at value (mode 1 only).
- cfg_repeat  input  1  1 = re-arm after a burst, 0 = return to IDLE.
- arm  input  1  IDLE -> ARMED.
- disarm  input  1  any state -> IDLE; has priority over arm.
- in_valid  input  1  input beat valid.
- in_data  input  WIDTH  golden data.
- out_valid  output  1  registered copy of in_valid.
- r_a, r_b, r_c  output  WIDTH each  replica outputs.
- data_out  output  WIDTH  registered bitwise majority of the three corrupted replicas.
- state_o  output  2  current FSM state.
- injecting  output  1  high when the beat currently on the outputs was corrupted.
- inject_cnt  output  16  count of corrupted beats; saturates at 0xFFFF.

Behaviour:
- Reset: out_valid=0, r_a=r_b=r_c=0, data_out=0, injecting=0, inject_cnt=0, state=IDLE, counters cleared, config registers cleared (cfg_tgt=0, so no corruption).
- Reset mid-burst aborts immediately; no residual corruption afterwards.
- Datapath: fixed 1-cycle latency. On every clock:
  - out_valid <= in_valid.
  - r_x <= corrupt_x(in_data).
  - data_out <= maj(corrupt_a, corrupt_b, corrupt_c).
  - Outputs hold their value when in_valid=0.
- corrupt_x applies only if all of the following hold: in_valid, state==ACTIVE, cfg_tgt selects replica x, disarm=0.
  - mode 0: d ^ cfg_mask.
  - mode 1: (d & ~cfg_mask) | (cfg_val & cfg_mask).
  - Otherwise corrupt_x = d.
- FSM states: IDLE=0, ARMED=1, ACTIVE=2.
  - IDLE: cfg_load latches config; arm -> ARMED with trig_cnt=0.
  - ARMED: each valid beat with ((in_data ^ cfg_trig_pat) & cfg_trig_mask)==0 increments trig_cnt. The beat that makes trig_cnt reach max(cfg_trig_n,1) moves to ACTIVE with burst_cnt=0. That triggering beat is NOT corrupted; corruption starts on the next valid beat. Non-matching beats do not reset trig_cnt.
  - ACTIVE: each valid beat is corrupted and increments burst_cnt. On the beat where burst_cnt reaches max(cfg_burst,1): go to ARMED (trig_cnt=0) if cfg_repeat, else go to IDLE. Invalid cycles do not advance counters.
  - disarm in any state: next state IDLE, counters cleared; the same-cycle beat is not corrupted.
  - arm outside IDLE: ignored.
- injecting <= (corruption applied to any replica on this beat); inject_cnt increments by 1 on such beats.
- cfg_tgt=0 in ACTIVE: FSM advances normally, no corruption, injecting stays 0.
- Counters are CNT_W wide. Compare against the clamped config value; no wrap is possible because cfg values are at most 2^CNT_W-1.

Decomposition:
- Shared package tmr_pkg holds:
  - state enum (IDLE/ARMED/ACTIVE) and its encoding;
  - mode constants (MODE_FLIP=0, MODE_STUCK=1);
  - replica-select bit positions.
- One sub-module, tmr_majority_voter: combinational bitwise 2-of-3 majority, WIDTH parameter. It is reused by the monitor-side testbench as the reference voter.

Test Plan:
- No arm; stream 0x00..0x0F with in_valid=1 -> r_a=r_b=r_c=data_out=in_data one cycle later; injecting=0; inject_cnt=0.
- Config pat=0xA5, trig_mask=0xFF, trig_n=2, burst=3, tgt=001, mode 0, mask=0x0F, repeat=0; arm; send 0xA5, 0x11, 0xA5, 0x10, 0x20, 0x30, 0x40 -> only 0x10/0x20/0x30 corrupt r_a (0x1F, 0x2F, 0x3F); r_b, r_c and data_out stay clean; inject_cnt=3; state returns to IDLE.
- Same config with tgt=011, mode 1, val=0xFF, mask=0xF0 -> burst beats show r_a=r_b=data_out=d|0xF0, r_c clean; the monitor sees a mismatch streak of 3 and raises flags.
- repeat=1, trig_n=1, burst=1, trigger on 0x55 -> every beat immediately following a 0x55 is corrupted; state cycles ARMED->ACTIVE->ARMED.
- Assert disarm during ACTIVE in the same cycle as a valid beat -> that beat is clean; state=IDLE next cycle; later triggers are ignored until re-armed.
- Assert rst mid-burst -> all outputs 0, inject_cnt=0, state=IDLE; cfg_load while ARMED -> ignored (old config remains in effect).
